dtc_rx: RTL and testbench

Serial-to-parallel receiver for the DTC serial link: the far end of the double-buffered transmitter that streams 256-bit BRAM words LSB-first, one bit per clock. It locks to a frame-start marker and reassembles contiguous 256-bit words. Completed words are queued in a two-slot holding buffer and written to a 24-word receive BRAM with wrap-around addressing. It sits between the serial line (or loopback) and the receive BRAM, and exposes sticky status for ChipScope/VIO observation.

---
 rtl/dtc_pkg.sv | 13 +
 rtl/dtc_rx_hold_q.sv | 53 +++++
 rtl/dtc_rx.sv | 120 ++++++++++++
 tb/tb_dtc_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared constants and types for the DTC serial link (transmitter and receiver).
package dtc_pkg;

    localparam int WORD_W = 256;
    localparam int DEPTH  = 24;
    localparam int ADDR_W = 5;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/dtc_rx_hold_q.sv
// Two-entry holding FIFO between the DTC receive shifter and the receive BRAM.
// A push while full is taken only when a pop happens in the same cycle; otherwise it is dropped.
module dtc_rx_hold_q
    import dtc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] din,
    input  logic              pop,
    output logic [WORD_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    logic [1:0][WORD_W-1:0] mem_q, mem_d;
    logic [1:0]             count_q, count_d;
    logic                   pop_ok;
    logic                   push_ok;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign dout  = mem_q[0];

    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        drop    = push & full & ~pop_ok;
        mem_d   = mem_q;
        count_d = count_q;
        if (pop_ok) begin
            mem_d[0] = mem_q[1];
            count_d  = count_q - 2'd1;
        end
        // The new word lands just behind whatever survives the pop.
        if (push_ok) begin
            mem_d[count_d[0]] = din;
            count_d           = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dtc_rx.sv
// DTC serial receiver: locks on frame_start, reassembles LSB-first 256-bit words
// and writes them through a two-slot holding queue into a wrap-around receive BRAM.
module dtc_rx
    import dtc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sr_in,
    input  logic              sr_valid,
    input  logic              frame_start,
    input  logic              bram_rdy,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_din,
    output logic              locked,
    output logic              wrap,
    output logic              sync_err,
    output logic              overflow,
    output logic [15:0]       word_count
);

    rx_state_e          state_q, state_d;
    logic [7:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               sync_err_q, sync_err_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        word_count_q, word_count_d;
    logic               push;
    logic               q_empty;
    logic               q_drop;
    logic               unused_q_full;
    logic               last_addr;

    dtc_rx_hold_q u_hold_q (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shreg_d),
        .pop   (bram_we),
        .dout  (bram_din),
        .empty (q_empty),
        .full  (unused_q_full),
        .drop  (q_drop)
    );

    assign bram_we    = ~q_empty & bram_rdy;
    assign last_addr  = (addr_q == ADDR_W'(DEPTH - 1));
    assign wrap       = bram_we & last_addr;
    assign bram_addr  = addr_q;
    assign locked     = (state_q == SHIFT);
    assign sync_err   = sync_err_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sync_err_d = sync_err_q;
        push       = 1'b0;
        if (sr_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        state_d   = SHIFT;
                        shreg_d   = {sr_in, {(WORD_W-1){1'b0}}};
                        bit_cnt_d = 8'd1;
                    end
                end
                SHIFT: begin
                    if (frame_start) begin
                        // A marker on a word boundary is a harmless realignment.
                        if (bit_cnt_q != 8'd0) begin
                            sync_err_d = 1'b1;
                        end
                        shreg_d   = {sr_in, {(WORD_W-1){1'b0}}};
                        bit_cnt_d = 8'd1;
                    end else begin
                        shreg_d   = {sr_in, shreg_q[WORD_W-1:1]};
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        push      = (bit_cnt_q == 8'hFF);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        addr_d       = addr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q | q_drop;
        if (bram_we) begin
            addr_d       = last_addr ? '0 : addr_q + ADDR_W'(1);
            word_count_d = word_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 8'd0;
            shreg_q      <= '0;
            addr_q       <= '0;
            sync_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            addr_q       <= addr_d;
            sync_err_q   <= sync_err_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_dtc_rx.sv
// Directed-sequence bench for dtc_rx with random word contents; a write monitor
// checks every BRAM write against the queue of words the bench expects to land.
module tb_dtc_rx;
    import dtc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              sr_in;
    logic              sr_valid;
    logic              frame_start;
    logic              bram_rdy;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [WORD_W-1:0] bram_din;
    logic              locked;
    logic              wrap;
    logic              sync_err;
    logic              overflow;
    logic [15:0]       word_count;

    int total = 0;
    int bad = 0;
    logic [WORD_W-1:0] exp_q[$];
    int exp_addr = 0;
    int exp_written = 0;

    dtc_rx dut (
        .clk         (clk),
        .rst         (rst),
        .sr_in       (sr_in),
        .sr_valid    (sr_valid),
        .frame_start (frame_start),
        .bram_rdy    (bram_rdy),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .locked      (locked),
        .wrap        (wrap),
        .sync_err    (sync_err),
        .overflow    (overflow),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: each write must carry the oldest expected word at the next ring address.
    always @(negedge clk) begin
        if (!rst && bram_we) begin
            if (exp_q.size() == 0) begin
                check1("spurious_we", bram_we, 1'b0);
            end else begin
                checkw("bram_din", bram_din, exp_q.pop_front());
                checkw("bram_addr", WORD_W'(bram_addr), WORD_W'(exp_addr));
                check1("wrap", wrap, exp_addr == DEPTH - 1);
                exp_addr = (exp_addr == DEPTH - 1) ? 0 : exp_addr + 1;
            end
        end else if (!rst && wrap) begin
            check1("wrap_idle", wrap, 1'b0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sr_valid    = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [WORD_W-1:0] w, input int lo, input int hi,
                             input bit marker, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            @(posedge clk);
            #1;
            sr_valid    = 1'b1;
            sr_in       = w[i];
            frame_start = marker && (i == lo);
        end
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic expect_word(input logic [WORD_W-1:0] w);
        exp_q.push_back(w);
        exp_written++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        sr_valid    = 1'b0;
        frame_start = 1'b0;
        exp_q.delete();
        exp_addr    = 0;
        exp_written = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check1({tag, "_we"}, bram_we, 1'b0);
        checkw({tag, "_addr"}, WORD_W'(bram_addr), '0);
        checkw({tag, "_din"}, bram_din, '0);
        check1({tag, "_locked"}, locked, 1'b0);
        check1({tag, "_wrap"}, wrap, 1'b0);
        check1({tag, "_sync_err"}, sync_err, 1'b0);
        check1({tag, "_overflow"}, overflow, 1'b0);
        checkw({tag, "_word_count"}, WORD_W'(word_count), '0);
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        rst         = 1'b1;
        sr_in       = 1'b0;
        sr_valid    = 1'b0;
        frame_start = 1'b0;
        bram_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Hunting: unmarked bits are ignored.
        send_bits(rand_word(), 0, 39, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check1("hunt_locked", locked, 1'b0);

        // Basic receive of 0x...0001, locked timing and one-cycle write latency.
        w = '0;
        w[0] = 1'b1;
        expect_word(w);
        send_bits(w, 0, 0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check1("locked_rise", locked, 1'b1);
        send_bits(w, 1, WORD_W - 1, 1'b0, 1'b0);
        @(negedge clk);
        check1("basic_we_early", bram_we, 1'b0);
        idle(1);
        @(negedge clk);
        check1("basic_we_latency", bram_we, 1'b1);
        w = rand_word();
        expect_word(w);
        send_bits(w, 0, WORD_W - 1, 1'b0, 1'b0);
        idle(2);
        checkw("basic_count", WORD_W'(word_count), WORD_W'(exp_written));

        // Wrap: 25 back-to-back words tagged k in bits [7:0].
        do_reset();
        for (int k = 0; k < 25; k++) begin
            w = rand_word();
            w[7:0] = 8'(k);
            expect_word(w);
            send_bits(w, 0, WORD_W - 1, k == 0, 1'b0);
        end
        idle(3);
        checkw("wrap_count", WORD_W'(word_count), WORD_W'(25));

        // Noncontiguous bits with a boundary realignment marker (no error).
        for (int k = 0; k < 3; k++) begin
            w = rand_word();
            expect_word(w);
            send_bits(w, 0, WORD_W - 1, k == 0, 1'b1);
            @(negedge clk);
            check1("gap_we_early", bram_we, 1'b0);
            idle(1);
            @(negedge clk);
            check1("gap_we_latency", bram_we, 1'b1);
        end
        check1("realign_no_err", sync_err, 1'b0);

        // Misalignment: marker at bit 100 drops the partial word.
        send_bits(rand_word(), 0, 99, 1'b0, 1'b0);
        w = rand_word();
        expect_word(w);
        send_bits(w, 0, 0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check1("sync_err_set", sync_err, 1'b1);
        send_bits(w, 1, WORD_W - 1, 1'b0, 1'b0);
        idle(3);
        check1("sync_err_sticky", sync_err, 1'b1);

        // Backpressure: two words held, third dropped, then drained back to back.
        bram_rdy = 1'b0;
        w1 = rand_word();
        w2 = rand_word();
        expect_word(w1);
        expect_word(w2);
        send_bits(w1, 0, WORD_W - 1, 1'b0, 1'b0);
        send_bits(w2, 0, WORD_W - 1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check1("bp_no_overflow_yet", overflow, 1'b0);
        send_bits(rand_word(), 0, WORD_W - 1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check1("bp_overflow", overflow, 1'b1);
        check1("bp_stalled", bram_we, 1'b0);
        checkw("bp_head", bram_din, w1);
        @(posedge clk);
        #1;
        bram_rdy = 1'b1;
        @(negedge clk);
        check1("bp_drain0", bram_we, 1'b1);
        @(negedge clk);
        check1("bp_drain1", bram_we, 1'b1);
        @(negedge clk);
        check1("bp_drain_done", bram_we, 1'b0);
        checkw("bp_count", WORD_W'(word_count), WORD_W'(exp_written[15:0]));

        // Reset mid-word.
        send_bits(rand_word(), 0, 127, 1'b0, 1'b0);
        do_reset();
        check_reset_outputs("rst_midword");

        // Reset with the queue full, then unmarked bits must be ignored.
        bram_rdy = 1'b0;
        send_bits(rand_word(), 0, WORD_W - 1, 1'b1, 1'b0);
        send_bits(rand_word(), 0, WORD_W - 1, 1'b0, 1'b0);
        idle(1);
        do_reset();
        bram_rdy = 1'b1;
        check_reset_outputs("rst_full");
        send_bits(rand_word(), 0, WORD_W - 1, 1'b0, 1'b0);
        send_bits(rand_word(), 0, 43, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        check1("rst_hunt_locked", locked, 1'b0);
        w = rand_word();
        expect_word(w);
        send_bits(w, 0, WORD_W - 1, 1'b1, 1'b0);
        idle(3);
        checkw("final_count", WORD_W'(word_count), WORD_W'(exp_written[15:0]));
        checkw("final_pending", WORD_W'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
